mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage_pkg: bus structures shared by the MEM stage and its neighbours.
//
// mem_stage: memory-access pipeline stage. It accepts one instruction from
// pre-MEM and waits for that instruction's data response when a request was
// issued. It then extracts and aligns the load result and hands it to
// write-back. Flushes that hit an outstanding request leave a single pending
// response, which is absorbed silently before the stage accepts new work.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ws_allowin        write-back can accept this cycle
//   ms_allowin        this stage can accept from pre-MEM this cycle
//   pms_to_ms_bus     inbound instruction bus from pre-MEM
//   data_data_ok      response strobe for the oldest outstanding data request
//   data_rdata        load data, valid with data_data_ok
//   pipeline_flush    eret / ex flush request
//   ms_to_ws_bus      outbound bus to write-back
//   ms_forward_bus    bypass info for earlier stages (busy = stalled load)
//   ms_wr_disable     stage holds a valid excepting instruction

package mem_stage_pkg;

   typedef struct packed {
      logic       ex;
      logic [4:0] excode;
   } exception_t;

   typedef struct packed {
      logic       eret;
      logic       ex;
   } pipeline_flush_t;

   // load_op is one-hot {lwr, lwl, lw, lhu, lh, lbu, lb}
   typedef struct packed {
      logic        valid;
      logic [6:0]  load_op;
      logic        req_ok;
      logic        res_from_mem;
      logic        rf_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] rt_value;
      logic [31:0] pc;
      exception_t  exception;
   } pms_to_ms_bus_t;

   typedef struct packed {
      logic        valid;
      logic        rf_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
      exception_t  exception;
   } ms_to_ws_bus_t;

   typedef struct packed {
      logic        busy;
      logic [4:0]  dest;
      logic [31:0] final_result;
   } ms_forward_bus_t;

endpackage

module mem_stage
   import mem_stage_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            ws_allowin,
   output logic            ms_allowin,
   input  pms_to_ms_bus_t  pms_to_ms_bus,
   input  logic            data_data_ok,
   input  logic [31:0]     data_rdata,
   input  pipeline_flush_t pipeline_flush,
   output ms_to_ws_bus_t   ms_to_ws_bus,
   output ms_forward_bus_t ms_forward_bus,
   output logic            ms_wr_disable
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t         state_q, state_d;
   logic           ms_valid_q, ms_valid_d;
   pms_to_ms_bus_t bus_q, bus_d;
   logic [31:0]    rdata_buf_q, rdata_buf_d;
   logic           discard_q, discard_d;

   logic        ms_ready_go;
   logic        flush;
   logic [31:0] mem_word;
   logic [1:0]  addr;
   logic [7:0]  mbyte;
   logic [15:0] mhalf;
   logic [31:0] load_val;
   logic [31:0] final_result;

   assign flush = pipeline_flush.eret | pipeline_flush.ex;

   assign ms_ready_go = (state_q == IDLE) || (state_q == DONE) ||
                        ((state_q == WAIT) && data_data_ok && !discard_q);

   assign ms_allowin = !discard_q && (!ms_valid_q || (ms_ready_go && ws_allowin));

   // Next-state logic; later assignments take priority (leave < accept < flush).
   always_comb begin
      state_d     = state_q;
      ms_valid_d  = ms_valid_q;
      bus_d       = bus_q;
      rdata_buf_d = rdata_buf_q;
      discard_d   = discard_q;

      // The response owed to a flushed instruction is absorbed here.
      if (discard_q && data_data_ok)
         discard_d = 1'b0;

      if ((state_q == WAIT) && data_data_ok && !discard_q) begin
         rdata_buf_d = data_rdata;
         state_d     = DONE;
      end

      if (ms_valid_q && ms_ready_go && ws_allowin)
         state_d = IDLE;

      if (ms_allowin) begin
         ms_valid_d = pms_to_ms_bus.valid;
         if (pms_to_ms_bus.valid) begin
            bus_d   = pms_to_ms_bus;
            state_d = pms_to_ms_bus.req_ok ? WAIT : IDLE;
         end
      end

      if (flush) begin
         ms_valid_d = 1'b0;
         state_d    = IDLE;
         if ((state_q == WAIT) && !data_data_ok)
            discard_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ms_valid_q  <= 1'b0;
         bus_q       <= '0;
         rdata_buf_q <= '0;
         discard_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ms_valid_q  <= ms_valid_d;
         bus_q       <= bus_d;
         rdata_buf_q <= rdata_buf_d;
         discard_q   <= discard_d;
      end
   end

   // In the response cycle data comes straight from the bus; once parked in
   // DONE it comes from the capture buffer.
   always_comb begin
      mem_word = (state_q == DONE) ? rdata_buf_q : data_rdata;
      addr     = bus_q.result[1:0];

      case (addr)
         2'd0:    mbyte = mem_word[7:0];
         2'd1:    mbyte = mem_word[15:8];
         2'd2:    mbyte = mem_word[23:16];
         default: mbyte = mem_word[31:24];
      endcase
      mhalf = addr[1] ? mem_word[31:16] : mem_word[15:0];

      load_val = mem_word;
      if (bus_q.load_op[0])
         load_val = {{24{mbyte[7]}}, mbyte};
      else if (bus_q.load_op[1])
         load_val = {24'd0, mbyte};
      else if (bus_q.load_op[2])
         load_val = {{16{mhalf[15]}}, mhalf};
      else if (bus_q.load_op[3])
         load_val = {16'd0, mhalf};
      else if (bus_q.load_op[5]) begin
         case (addr)
            2'd0:    load_val = {mem_word[7:0],  bus_q.rt_value[23:0]};
            2'd1:    load_val = {mem_word[15:0], bus_q.rt_value[15:0]};
            2'd2:    load_val = {mem_word[23:0], bus_q.rt_value[7:0]};
            default: load_val = mem_word;
         endcase
      end else if (bus_q.load_op[6]) begin
         case (addr)
            2'd0:    load_val = mem_word;
            2'd1:    load_val = {bus_q.rt_value[31:24], mem_word[31:8]};
            2'd2:    load_val = {bus_q.rt_value[31:16], mem_word[31:16]};
            default: load_val = {bus_q.rt_value[31:8],  mem_word[31:24]};
         endcase
      end

      final_result = bus_q.res_from_mem ? load_val : bus_q.result;
   end

   always_comb begin
      ms_to_ws_bus              = '0;
      ms_to_ws_bus.valid        = ms_valid_q && ms_ready_go;
      ms_to_ws_bus.rf_we        = bus_q.rf_we && !bus_q.exception.ex;
      ms_to_ws_bus.dest         = bus_q.dest;
      ms_to_ws_bus.final_result = final_result;
      ms_to_ws_bus.pc           = bus_q.pc;
      ms_to_ws_bus.exception    = bus_q.exception;

      ms_forward_bus              = '0;
      ms_forward_bus.busy         = ms_valid_q && bus_q.res_from_mem && !ms_ready_go;
      ms_forward_bus.dest         = ms_valid_q ? bus_q.dest : 5'd0;
      ms_forward_bus.final_result = final_result;
   end

   assign ms_wr_disable = ms_valid_q & bus_q.exception.ex;

endmodule
